// File: rtl/multiplier_4bit_core_pkg.sv
// Shared widths and types for the registered array multiplier.
package multiplier_4bit_core_pkg;

  localparam int unsigned DefaultWidth = 4;
  localparam int unsigned ProductWidth = 2 * DefaultWidth;

  typedef logic [ProductWidth-1:0] product_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used throughout the multiplier adder array.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/multiplier_4bit_core.sv
// Unsigned array multiplier: AND-gate partial products summed by ripple rows of
// full adders, with the product captured in a single register.
module multiplier_4bit_core
  import multiplier_4bit_core_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   P
);

  logic [2*WIDTH-1:0] product_d;

  // Row i holds the running sum after adding partial product i. Bit 0 of each
  // row is final and becomes product bit i; the upper bits feed the next row.
  for (genvar i = 0; i < WIDTH; i++) begin : gen_row
    logic [WIDTH-1:0] pp;
    logic [WIDTH:0]   sum;

    assign pp = A & {WIDTH{B[i]}};

    if (i == 0) begin : gen_first
      assign sum = {1'b0, pp};
    end else begin : gen_add
      for (genvar j = 0; j < WIDTH; j++) begin : gen_bit
        logic cin;
        logic s;
        logic co;

        // Position 0 has no incoming carry, so it acts as a half adder.
        if (j == 0) begin : gen_half
          assign cin = 1'b0;
        end else begin : gen_chain
          assign cin = gen_bit[j-1].co;
        end

        full_adder u_fa (
          .a    (gen_row[i-1].sum[j+1]),
          .b    (pp[j]),
          .cin  (cin),
          .s    (s),
          .cout (co)
        );

        assign sum[j] = s;
      end
      assign sum[WIDTH] = gen_bit[WIDTH-1].co;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : gen_low_bits
    assign product_d[i] = gen_row[i].sum[0];
  end

  assign product_d[2*WIDTH-1:WIDTH] = gen_row[WIDTH-1].sum[WIDTH:1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      P <= '0;
    end else begin
      P <= product_d;
    end
  end

endmodule

// File: tb/tb_multiplier_4bit_core.sv
// Directed and exhaustive checks of the registered 4-bit multiplier using a
// scoreboard of expected products popped one cycle after each drive.
module tb_multiplier_4bit_core;

  logic       clk;
  logic       rst_n;
  logic [3:0] A;
  logic [3:0] B;
  logic [7:0] P;

  int unsigned checks;
  int unsigned passes;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  multiplier_4bit_core #(
    .WIDTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .P     (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_now(input string tag, input logic [7:0] expected);
    checks++;
    assert (P === expected) passes++;
    else $error("FAIL %s: P=%0d expected %0d", tag, P, expected);
  endtask

  task automatic check_pop();
    logic [7:0] e;
    string      t;
    if (exp_q.size() == 0) begin
      checks++;
      $error("FAIL scoreboard_empty: P=%0d expected none", P);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_now(t, e);
    end
  endtask

  // Present operands and reset, record the reference result, then check it
  // one cycle later (sampled 1 time unit after the edge).
  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic rn,
                       input string tag);
    logic [7:0] wa;
    logic [7:0] wb;
    wa    = {4'd0, a};
    wb    = {4'd0, b};
    A     = a;
    B     = b;
    rst_n = rn;
    exp_q.push_back(rn ? wa * wb : 8'd0);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  initial begin
    checks = 0;
    passes = 0;
    A      = 4'd0;
    B      = 4'd0;
    rst_n  = 1'b0;
    @(negedge clk);

    // Reset with maximal operands, then release.
    drive(4'd15, 4'd15, 1'b0, "reset_0");
    drive(4'd15, 4'd15, 1'b0, "reset_1");
    drive(4'd15, 4'd15, 1'b1, "reset_release");

    // Directed sequence.
    drive(4'd5,  4'd11, 1'b1, "dir_5x11");
    drive(4'd7,  4'd15, 1'b1, "dir_7x15");
    drive(4'd10, 4'd12, 1'b1, "dir_10x12");
    drive(4'd13, 4'd2,  1'b1, "dir_13x2");
    drive(4'd10, 4'd5,  1'b1, "dir_10x5");
    drive(4'd10, 4'd4,  1'b1, "dir_10x4");

    // Boundaries.
    drive(4'd0,  4'd9,  1'b1, "bnd_0x9");
    drive(4'd9,  4'd0,  1'b1, "bnd_9x0");
    drive(4'd1,  4'd15, 1'b1, "bnd_1x15");
    drive(4'd15, 4'd15, 1'b1, "bnd_15x15");
    drive(4'd8,  4'd8,  1'b1, "bnd_8x8");

    // Mid-stream reset: the (7,15) product is dropped, and rst_n toggling
    // between edges must not disturb P.
    drive(4'd3, 4'd3, 1'b1, "mid_pre");
    A     = 4'd7;
    B     = 4'd15;
    rst_n = 1'b0;
    #1 check_now("mid_async_0", 8'd9);
    rst_n = 1'b1;
    #1 check_now("mid_async_1", 8'd9);
    rst_n = 1'b0;
    #1;
    drive(4'd7, 4'd15, 1'b0, "mid_reset");
    drive(4'd3, 4'd3,  1'b1, "mid_release");

    // Operands wiggling between edges only matter at the edge.
    A = 4'd15;
    B = 4'd14;
    #2 check_now("between_edges", 8'd9);
    drive(4'd12, 4'd11, 1'b1, "late_change");

    // Hold: P stays at 42 at every edge and mid-cycle.
    for (int k = 0; k < 5; k++) begin
      drive(4'd6, 4'd7, 1'b1, "hold_edge");
      #4 check_now("hold_mid", 8'd42);
    end

    // Exhaustive back-to-back sweep.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        drive(a[3:0], b[3:0], 1'b1, $sformatf("sweep_%0dx%0d", a, b));
      end
    end

    checks++;
    assert (exp_q.size() == 0) passes++;
    else $error("FAIL scoreboard_leftover: size=%0d expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
